// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_xmit_arbiter_if.sv
// Bundle of requester, transmitter and status signals around the arbiter.
//
// Handshake: requester i holds req_valid[i] high with a stable byte on
// req_data[8i+7:8i]; the byte is taken in the cycle req_ack[i] pulses, and the
// requester drops valid or presents its next byte in the following cycle.
// Valid may be withdrawn at any time before ack. Toward the transmitter,
// tx_xmitH is a one-cycle launch strobe and tx_dataH holds until tx_doneH
// (high = idle) returns high after having dropped.
interface uart_xmit_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import uart_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req_valid;
    logic [UART_DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ack;
    logic                           tx_xmitH;
    logic [UART_DATA_W-1:0]         tx_dataH;
    logic                           tx_doneH;
    logic                           busy;
    logic [IDX_W-1:0]               grant_id;
    logic                           tmo_err;
    logic [FRAME_CNT_W-1:0]         frame_cnt;
    arb_state_t                     dbg_state;

    // Arbiter side
    modport master (
        input  req_valid, req_data, tx_doneH,
        output req_ack, tx_xmitH, tx_dataH, busy, grant_id, tmo_err,
               frame_cnt, dbg_state
    );

    // Producers / transmitter side
    modport slave (
        output req_valid, req_data, tx_doneH,
        input  req_ack, tx_xmitH, tx_dataH, busy, grant_id, tmo_err,
               frame_cnt, dbg_state
    );

endinterface

// File: rtl/uart_xmit_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request after the last grant, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);

    logic [IDX_W-1:0] w_cand;

    // Scan from farthest to nearest so the nearest candidate after i_last wins
    always_comb begin
        o_found = 1'b0;
        o_idx   = i_last;
        w_cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = IDX_W'((int'(i_last) + k) % NUM_REQ);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/uart_xmit_arbiter.sv
// Round-robin sequencer sharing one UART transmitter among NUM_REQ producers,
// with a wait-state watchdog and a completed-frame counter.
module uart_xmit_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int TMO_CYCLES = 1023,
    parameter int TMO_W      = 10
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    uart_xmit_arbiter_if.master  bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t             r_state;
    arb_state_t             w_next;
    logic [IDX_W-1:0]       r_grant;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_found;
    logic [TMO_W-1:0]       r_tmo_cnt;
    logic [UART_DATA_W-1:0] r_data;
    logic [NUM_REQ-1:0]     r_ack;
    logic                   r_xmit;
    logic                   r_busy;
    logic                   r_tmo_err;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic                   w_launch;
    logic                   w_abort;
    logic                   w_frame_done;
    logic                   w_tmo_hit;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req   (bus.req_valid),
        .i_last  (r_grant),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TMO_CYCLES));

    // Next-state decode; a normal exit takes precedence over the watchdog
    always_comb begin
        w_next       = r_state;
        w_launch     = 1'b0;
        w_abort      = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_found && bus.tx_doneH) begin
                    w_next   = LAUNCH;
                    w_launch = 1'b1;
                end
            end
            LAUNCH: w_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!bus.tx_doneH) begin
                    w_next = WAIT_DONE;
                end else if (w_tmo_hit) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (bus.tx_doneH) begin
                    w_next       = IDLE;
                    w_frame_done = 1'b1;
                end else if (w_tmo_hit) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Latch the winner and its byte on the arbitration edge; held until the next win
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_grant <= IDX_W'(NUM_REQ - 1);
            r_data  <= '0;
        end else if (w_launch) begin
            r_grant <= w_pick_idx;
            r_data  <= bus.req_data[{w_pick_idx, 3'b000} +: UART_DATA_W];
        end
    end

    // Registered strobes: launch/ack live only in LAUNCH, error only after abort
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_xmit    <= 1'b0;
            r_ack     <= '0;
            r_tmo_err <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_xmit    <= w_launch;
            r_ack     <= w_launch ? (NUM_REQ'(1) << w_pick_idx) : '0;
            r_tmo_err <= w_abort;
            r_busy    <= (w_next != IDLE);
        end
    end

    // Watchdog: zeroed while launching, counts through both wait states
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == LAUNCH) begin
            r_tmo_cnt <= '0;
        end else if (r_state == WAIT_BUSY || r_state == WAIT_DONE) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Completed-frame counter, wraps naturally
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)           r_frame_cnt <= '0;
        else if (w_frame_done) r_frame_cnt <= r_frame_cnt + 1'b1;
    end

    assign bus.req_ack   = r_ack;
    assign bus.tx_xmitH  = r_xmit;
    assign bus.tx_dataH  = r_data;
    assign bus.busy      = r_busy;
    assign bus.grant_id  = r_grant;
    assign bus.tmo_err   = r_tmo_err;
    assign bus.frame_cnt = r_frame_cnt;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_uart_xmit_arbiter.sv
// Bench for uart_xmit_arbiter: directed scenarios plus randomized rounds
// checked against a queue-based requester/round-robin model.
module tb_uart_xmit_arbiter;
  import uart_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 20;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  uart_xmit_arbiter_if #(.NUM_REQ(N)) bus();

  uart_xmit_arbiter #(
    .NUM_REQ    (N),
    .TMO_CYCLES (TMO),
    .TMO_W      (10)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus.master)
  );

  // ---------------- clock ----------------
  always #5 sys_clk = ~sys_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- transmitter model ----------------
  // Done drops 2 cycles after the strobe, then one cycle per line bit.
  logic       tx_done_m = 1'b1;
  logic       pend = 1'b0;
  logic [3:0] bit_i = 4'd0;
  bit         tx_stuck = 1'b0;
  bit         tx_force_low = 1'b0;
  logic       rx_bits[$];

  assign bus.tx_doneH = tx_done_m & ~tx_force_low;

  always @(posedge sys_clk) begin
    if (pend) begin
      pend <= 1'b0;
      tx_done_m <= 1'b0;
      rx_bits.push_back(1'b0);
      bit_i <= 4'd0;
    end else if (!tx_done_m) begin
      if (bit_i < 4'd8) begin
        rx_bits.push_back(bus.tx_dataH[bit_i[2:0]]);
        bit_i <= bit_i + 4'd1;
      end else if (bit_i == 4'd8) begin
        rx_bits.push_back(1'b1);
        bit_i <= 4'd9;
      end else begin
        tx_done_m <= 1'b1;
      end
    end else if (bus.tx_xmitH && !tx_stuck) begin
      pend <= 1'b1;
    end
  end

  // ---------------- requester / arbiter reference model ----------------
  logic [7:0] mem [N][8];
  int n_b [N];
  int rd  [N];
  int model_last;
  int model_frames;

  function automatic logic [N-1:0] model_valid();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = (rd[i] < n_b[i]);
    return v;
  endfunction

  // Lowest valid index above last, otherwise lowest valid index overall
  function automatic int ref_pick(logic [N-1:0] v, int last);
    int best;
    best = -1;
    for (int i = 0; i < N; i++)
      if (v[i] && i > last && best < 0) best = i;
    for (int i = 0; i < N; i++)
      if (v[i] && best < 0) best = i;
    return best;
  endfunction

  task automatic drive_reqs();
    logic [8*N-1:0] d;
    d = '0;
    for (int i = 0; i < N; i++)
      if (rd[i] < n_b[i]) d = d | ((8*N)'(mem[i][rd[i]]) << (8*i));
    bus.req_valid = model_valid();
    bus.req_data  = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      n_b[i] = 0;
      rd[i]  = 0;
    end
    drive_reqs();
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_grant"}, 32'(bus.grant_id), N - 1);
    chk({tag, "_fcnt"},  32'(bus.frame_cnt), 0);
    chk({tag, "_xmit"},  32'(bus.tx_xmitH), 0);
    chk({tag, "_ack"},   32'(bus.req_ack), 0);
    chk({tag, "_data"},  32'(bus.tx_dataH), 0);
    chk({tag, "_tmo"},   32'(bus.tmo_err), 0);
  endtask

  task automatic wait_strobe(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge sys_clk);
      if (bus.tx_xmitH) break;
    end
    chk("strobe_seen", 32'(bus.tx_xmitH), 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (!bus.busy) break;
      @(negedge sys_clk);
    end
    chk("busy_fall", 32'(bus.busy), 0);
  endtask

  // One full frame: launch checks against the model, then completion checks.
  task automatic serve(input int exp_fix);
    int w;
    int base;
    logic [9:0] got;
    logic [7:0] b;
    wait_strobe(60);
    if (!bus.tx_xmitH) return;
    base = rx_bits.size();
    w = ref_pick(model_valid(), model_last);
    if (w < 0) begin
      chk("unexpected_strobe_ack", 32'(bus.req_ack), 0);
      return;
    end
    b = mem[w][rd[w]];
    exp_q.push_back(b);
    chk("ack_onehot", 32'(bus.req_ack), 32'(1) << w);
    chk("tx_data", 32'(bus.tx_dataH), 32'(b));
    chk("grant_id", 32'(bus.grant_id), w);
    if (exp_fix >= 0) chk("grant_order", 32'(bus.grant_id), exp_fix);
    model_last = w;
    @(negedge sys_clk);
    chk("strobe_one_cycle", {30'd0, bus.tx_xmitH, |bus.req_ack}, 0);
    rd[w]++;
    drive_reqs();
    wait_idle(60);
    model_frames++;
    chk("frame_cnt", 32'(bus.frame_cnt), model_frames);
    chk("frame_len", rx_bits.size() - base, 10);
    if (rx_bits.size() - base == 10 && exp_q.size() > 0) begin
      got = '0;
      for (int k = 0; k < 10; k++) got[k] = rx_bits[base + k];
      b = exp_q.pop_front();
      chk("frame_bits", 32'(got), 32'({1'b1, b, 1'b0}));
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1 check_reset_vals(tag);
    model_last = N - 1;
    model_frames = 0;
    exp_q.delete();
    clear_reqs();
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n_seen;
    int total;
    logic seen;

    bus.req_valid = '0;
    bus.req_data  = '0;
    model_last = N - 1;
    model_frames = 0;
    clear_reqs();

    // Reset state
    repeat (2) @(negedge sys_clk);
    check_reset_vals("rst");
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Single request
    n_b[0] = 1; mem[0][0] = 8'hA5;
    drive_reqs();
    serve(0);
    chk("single_fcnt1", 32'(bus.frame_cnt), 1);

    // Contention: all valid continuously, order 0,1,2,3,0,1
    do_reset("rst2");
    for (int i = 0; i < N; i++) begin
      n_b[i] = 3;
      for (int j = 0; j < 3; j++) mem[i][j] = 8'($urandom_range(0, 255));
    end
    drive_reqs();
    for (int f = 0; f < 6; f++) serve(f % N);
    chk("contention_fcnt6", 32'(bus.frame_cnt), 6);

    // Skip idle bits: valid=1010 after grant 1
    clear_reqs();
    n_b[1] = 1; mem[1][0] = 8'h3C;
    n_b[3] = 1; mem[3][0] = 8'hC3;
    drive_reqs();
    serve(3);
    serve(1);

    // Timeout with a transmitter that never drops done
    tx_stuck = 1'b1;
    n_b[2] = rd[2] + 1; mem[2][rd[2]] = 8'h5A;
    drive_reqs();
    wait_strobe(20);
    chk("tmo_ack", 32'(bus.req_ack), 32'b0100);
    model_last = 2;
    n_seen = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge sys_clk);
      if (c == 1) begin
        rd[2]++;
        drive_reqs();
      end
      if (bus.tmo_err) begin
        n_seen = c;
        break;
      end
    end
    chk("tmo_latency", n_seen, 22);
    chk("tmo_busy", 32'(bus.busy), 0);
    chk("tmo_fcnt", 32'(bus.frame_cnt), model_frames);
    @(negedge sys_clk);
    chk("tmo_one_cycle", 32'(bus.tmo_err), 0);
    tx_stuck = 1'b0;
    n_b[3] = rd[3] + 1; mem[3][rd[3]] = 8'h77;
    drive_reqs();
    serve(3);

    // Transmitter not idle: hold off arbitration
    tx_force_low = 1'b1;
    n_b[2] = rd[2] + 1; mem[2][rd[2]] = 8'h81;
    drive_reqs();
    seen = 1'b0;
    repeat (10) begin
      @(negedge sys_clk);
      seen = seen | bus.tx_xmitH | (|bus.req_ack) | bus.busy;
    end
    chk("notidle_quiet", 32'(seen), 0);
    tx_force_low = 1'b0;
    serve(2);

    // Reset mid-frame (WAIT_DONE), then req 0 first
    n_b[1] = rd[1] + 1; mem[1][rd[1]] = 8'hE7;
    drive_reqs();
    wait_strobe(20);
    chk("mid_grant1", 32'(bus.grant_id), 1);
    @(negedge sys_clk);
    rd[1]++;
    drive_reqs();
    for (int c = 0; c < 20; c++) begin
      if (bus.dbg_state == WAIT_DONE) break;
      @(negedge sys_clk);
    end
    chk("mid_in_wait_done", 32'(bus.dbg_state), 32'(WAIT_DONE));
    do_reset("rst_mid");
    n_b[0] = 1; mem[0][0] = 8'h19;
    n_b[1] = 1; mem[1][0] = 8'h91;
    drive_reqs();
    serve(0);
    serve(1);

    // Randomized rounds against the reference model
    for (int r = 0; r < 6; r++) begin
      total = 0;
      for (int i = 0; i < N; i++) begin
        n_b[i] = $urandom_range(0, 3);
        rd[i] = 0;
        for (int j = 0; j < 3; j++) mem[i][j] = 8'($urandom_range(0, 255));
        total += n_b[i];
      end
      if (total == 0) begin
        n_b[$urandom_range(0, N - 1)] = 1;
        total = 1;
      end
      drive_reqs();
      for (int f = 0; f < total; f++) serve(-1);
      repeat ($urandom_range(0, 3)) @(negedge sys_clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_xmit_arbiter.md
Name: uart_xmit_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter between NUM_REQ byte producers.
- Picks a requester, launches one frame (one-cycle xmit strobe plus held data), then tracks the transmitter's registered done level until the frame completes.
- Sits between the producer blocks and the transmitter inside the UART top. Adds a timeout watchdog and a sent-frame counter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TMO_CYCLES, 1023, maximum cycles allowed in the wait states before abort; must be < 2**TMO_W.
- TMO_W, 10, width of the timeout counter.

Ports:
- sys_clk  in  1  single clock; all state on rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i: requester i has a byte pending.
- req_data  in  8*NUM_REQ  byte i at [8i+7:8i].
- req_ack  out  NUM_REQ  one-hot one-cycle pulse: byte i accepted.
- tx_xmitH  out  1  one-cycle launch strobe to transmitter.
- tx_dataH  out  8  byte to transmitter; held stable from launch to frame end.
- tx_doneH  in  1  transmitter done level: high when idle, low while sending, registered by the transmitter.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- tmo_err  out  1  one-cycle pulse on timeout abort.
- frame_cnt  out  16  count of completed frames; wraps 0xFFFF->0.

Behaviour:
- Reset values: state IDLE; req_ack=0, tx_xmitH=0, tx_dataH=0, busy=0, grant_id=NUM_REQ-1 (so req 0 has first priority), tmo_err=0, frame_cnt=0, timeout counter=0.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Arbitration happens only when |req_valid and tx_doneH=1.
  - The winner is the first set bit searching grant_id+1, grant_id+2, … modulo NUM_REQ.
  - On that edge: latch grant_id, latch tx_dataH=req_data[winner], go to LAUNCH.
  - If tx_doneH=0, remain in IDLE and do not arbitrate.
- LAUNCH (exactly 1 cycle):
  - tx_xmitH=1 and req_ack[grant_id]=1 are both registered outputs, high only in this cycle.
  - Next state is WAIT_BUSY.
- WAIT_BUSY:
  - Exit to WAIT_DONE on the first cycle tx_doneH=0.
  - The transmitter drops done 2 cycles after the strobe.
- WAIT_DONE:
  - When tx_doneH=1: frame_cnt+1, go to IDLE.
  - The next arbitration is no earlier than the following cycle.
- Timeout:
  - The counter clears on entry to WAIT_BUSY and increments each cycle in WAIT_BUSY or WAIT_DONE.
  - When it equals TMO_CYCLES and the exit condition is false: tmo_err pulse, go to IDLE, frame_cnt unchanged.
  - grant_id keeps the aborted requester, so the rotation continues past it.
  - Exit condition and timeout in the same cycle: the exit condition wins.
- Fairness: a requester granted once loses priority to every other valid requester until the rotation passes it.
- Requester rules:
  - The byte must be stable while valid.
  - Deassert valid or present the next byte in the cycle after req_ack.
  - Valid is not sampled outside IDLE.
  - Dropping valid before ack is a legal withdrawal.
- Minimum launch spacing: 4 cycles (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE).
- Reset mid-frame: all registers return to reset values immediately. Any tx_xmitH in progress is cut, no ack or error is produced, and no state survives.

Decomposition:
- Shared package uart_pkg:
  - state encoding typedef arb_state_t (IDLE=2'd0, LAUNCH=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3);
  - constants UART_DATA_W=8 and FRAME_CNT_W=16.
- One sub-module, rr_pick: purely combinational rotate-priority encoder.
  - Inputs: req vector and last grant.
  - Outputs: winner index and found flag.
- FSM, timeout counter and frame counter stay in uart_xmit_arbiter.

Test Plan:
- Single request:
  - Stimulus: req_valid=4'b0001, req_data[7:0]=8'hA5, model transmitter.
  - Required: tx_xmitH pulses once with tx_dataH=8'hA5, req_ack=4'b0001 in the same cycle, and busy falls after done returns high.
  - Also: frame_cnt=1 and a 10-bit serial frame 0,A5 LSB-first,1 on the line.
- Contention:
  - Stimulus: all four requesters valid continuously.
  - Required: grant order 0,1,2,3,0,1; each ack one-hot; frame_cnt=6 after six frames.
- Skip idle bits:
  - Stimulus: valid=4'b1010 after grant_id=1.
  - Required: next grant 3, then 1.
- Timeout:
  - Stimulus: tx_doneH held high after the strobe, TMO_CYCLES=20.
  - Required: tmo_err pulses exactly 21 cycles after entering WAIT_BUSY, return to IDLE, frame_cnt unchanged.
  - Then a next request to another requester is served normally.
- Transmitter not idle:
  - Stimulus: tx_doneH=0 while in IDLE with req_valid=4'b0100.
  - Required: no strobe and no ack until done=1, then ack 4'b0100.
- Reset mid-frame:
  - Stimulus: assert sys_rst while in WAIT_DONE.
  - Required: all outputs go to reset values asynchronously (grant_id=3, frame_cnt=0).
  - After release with req 0 valid: grant 0.
